// File: rtl/spi_host_master_if.sv
// Host-side SPI controller bundle: frame request/result handshake plus the
// four SPI pins. The controller uses the master modport.
interface spi_host_master_if #(
  parameter int STATE_SIZE = 41
);
  logic                  start;
  logic [15:0]           write_value;
  logic                  busy;
  logic                  done;
  logic [STATE_SIZE-1:0] state_out;
  logic                  sck;
  logic                  ss;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, write_value, miso,
    output busy, done, state_out, sck, ss, mosi
  );

  modport slave (
    output start, write_value, miso,
    input  busy, done, state_out, sck, ss, mosi
  );
endinterface

// File: rtl/spi_host_master.sv
// SPI mode-0 host: each accepted start shifts in STATE_SIZE bits of peripheral
// state on MISO while MOSI repeats a 16-bit command word every 16 bits.
module spi_host_master #(
  parameter int STATE_SIZE = 41,
  parameter int CLK_DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_host_master_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(STATE_SIZE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(STATE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LOW,
    S_HIGH,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DIV_W-1:0]      r_div, w_div_nxt;
  logic [BIT_W-1:0]      r_bitn, w_bitn_nxt;
  logic [15:0]           r_cmd, w_cmd_nxt;
  logic [STATE_SIZE-1:0] r_rx;
  logic [STATE_SIZE-1:0] r_state_out;
  logic                  r_busy, r_done, r_sck, r_ss, r_mosi;

  logic                  w_div_last;
  logic                  w_accept;
  logic                  w_sample;
  logic                  w_finish;
  logic                  w_active_nxt;
  logic [3:0]            w_bit_idx;

  assign w_div_last = (r_div == DIV_LAST);
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_sample   = (r_state == S_LOW)   && w_div_last;
  assign w_finish   = (r_state == S_TRAIL) && w_div_last;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bitn_nxt  = r_bitn;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LEAD;
          w_div_nxt   = '0;
          w_bitn_nxt  = '0;
        end
      end
      default: begin
        // Every non-idle phase lasts exactly CLK_DIV cycles.
        w_div_nxt = w_div_last ? '0 : r_div + 1'b1;
        if (w_div_last) begin
          unique case (r_state)
            S_LEAD:  w_state_nxt = S_LOW;
            S_LOW:   w_state_nxt = S_HIGH;
            S_HIGH: begin
              if (r_bitn == BIT_LAST) begin
                w_state_nxt = S_TRAIL;
              end else begin
                w_bitn_nxt  = r_bitn + 1'b1;
                w_state_nxt = S_LOW;
              end
            end
            S_TRAIL: w_state_nxt = S_GAP;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Pins are registered from the next state so they change cleanly on the
  // same edge the FSM moves, with ss dropping the cycle after acceptance.
  always_comb begin
    w_cmd_nxt    = w_accept ? bus.write_value : r_cmd;
    w_bit_idx    = 4'd15 - w_bitn_nxt[3:0];
    w_active_nxt = (w_state_nxt == S_LEAD) || (w_state_nxt == S_LOW) ||
                   (w_state_nxt == S_HIGH) || (w_state_nxt == S_TRAIL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bitn      <= '0;
      r_cmd       <= '0;
      // NOTE: the receive shifter and result register are reset as well so
      // state_out reads a defined zero before the first completed frame.
      r_rx        <= '0;
      r_state_out <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sck       <= 1'b0;
      r_ss        <= 1'b1;
      r_mosi      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bitn  <= w_bitn_nxt;
      r_cmd   <= w_cmd_nxt;

      // Sample just before the rising edge; MISO settled after the last fall.
      if (w_sample) begin
        r_rx <= {r_rx[STATE_SIZE-2:0], bus.miso};
      end

      r_done <= w_finish;
      if (w_finish) begin
        r_state_out <= r_rx;
      end

      r_busy <= (w_state_nxt != S_IDLE);
      r_ss   <= !w_active_nxt;
      r_sck  <= (w_state_nxt == S_HIGH);
      r_mosi <= w_active_nxt & w_cmd_nxt[w_bit_idx];
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.state_out = r_state_out;
  assign bus.sck       = r_sck;
  assign bus.ss        = r_ss;
  assign bus.mosi      = r_mosi;

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: behavioural SPI peripheral plus a
// scoreboard of expected frames checked whenever done pulses.
`timescale 1ns/1ps
module tb_spi_host_master;

  localparam int STATE_SIZE = 41;
  localparam int CLK_DIV    = 4;
  localparam int FRAME_CYC  = 1 + CLK_DIV * (2 * STATE_SIZE + 2);
  localparam int N_WR       = STATE_SIZE / 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_host_master_if #(.STATE_SIZE(STATE_SIZE)) bus ();

  spi_host_master #(
    .STATE_SIZE(STATE_SIZE),
    .CLK_DIV   (CLK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [STATE_SIZE-1:0] st;
    logic [15:0]           cmd;
    int                    start_cyc;  // negative: accepted CLK_DIV cycles after previous done
  } frame_t;

  frame_t                exp_q[$];
  logic [STATE_SIZE-1:0] load_q[$];
  int                    n_issued = 0;

  // ---------------- behavioural SPI peripheral ----------------
  logic [STATE_SIZE-1:0] p_sr;
  int                    p_rises = 0;
  logic [15:0]           p_wsh;
  logic [15:0]           p_writes[$];
  logic                  p_mosi[$];

  always @(negedge bus.ss) begin
    p_sr    = (load_q.size() != 0) ? load_q.pop_front() : '0;
    p_rises = 0;
    p_writes.delete();
    p_mosi.delete();
    #15 bus.miso = p_sr[STATE_SIZE-1];
  end

  always @(negedge bus.sck) begin
    p_sr = p_sr << 1;
    #15 bus.miso = p_sr[STATE_SIZE-1];
  end

  always @(posedge bus.sck) begin
    p_rises++;
    p_mosi.push_back(bus.mosi);
    p_wsh = {p_wsh[14:0], bus.mosi};
    if (p_rises % 16 == 0) p_writes.push_back(p_wsh);
  end

  // ---------------- monitor / scoreboard ----------------
  logic                  prev_ss = 1'b1, prev_sck = 1'b0;
  logic [STATE_SIZE-1:0] prev_so = '0;
  int run = 0, phase_bad = 0, rise_seen = 0, so_bad = 0;
  int ss_fall_cyc = 0, last_done = 0, n_done = 0;
  frame_t e;
  int     sc, errs;

  always @(negedge clk) begin
    if (rst) begin
      prev_ss  = 1'b1;
      prev_sck = 1'b0;
      prev_so  = bus.state_out;
      run      = 0;
    end else begin
      if (prev_ss && !bus.ss) begin
        ss_fall_cyc = cyc;
        phase_bad   = 0;
        rise_seen   = 0;
        run         = 0;
      end
      if (bus.sck != prev_sck) begin
        if (prev_sck && run != CLK_DIV) phase_bad++;
        if (!prev_sck && rise_seen > 0 && run != CLK_DIV) phase_bad++;
        if (!prev_sck) rise_seen++;
        run = 1;
      end else begin
        run++;
      end
      if (!bus.done && bus.state_out !== prev_so) so_bad++;

      if (bus.done) begin
        n_done++;
        check("done_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          sc = (e.start_cyc < 0) ? last_done + CLK_DIV : e.start_cyc;
          check("ss_fall_cycle", 64'(ss_fall_cyc - sc), 1);
          check("done_latency", 64'(cyc - sc), FRAME_CYC);
          check("state_out", bus.state_out, e.st);
          check("sck_rises", p_rises, STATE_SIZE);
          check("sck_phase_errs", phase_bad, 0);
          check("write_count", p_writes.size(), N_WR);
          foreach (p_writes[i]) check("write_value", p_writes[i], e.cmd);
          errs = 0;
          foreach (p_mosi[k]) if (p_mosi[k] !== e.cmd[15 - (k % 16)]) errs++;
          check("mosi_stream_errs", errs, 0);
        end
        last_done = cyc;
      end
      prev_ss  = bus.ss;
      prev_sck = bus.sck;
      prev_so  = bus.state_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 4 * FRAME_CYC) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) check("idle_timeout", bus.busy, 0);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 3 * FRAME_CYC) begin
      @(negedge clk);
      t++;
    end
    check("done_arrived", 64'(n_done >= target), 1);
  endtask

  task automatic issue_frame(input logic [STATE_SIZE-1:0] st, input logic [15:0] cmd);
    wait_idle();
    load_q.push_back(st);
    exp_q.push_back('{st, cmd, cyc});
    n_issued++;
    bus.write_value = cmd;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.write_value = 16'($urandom());
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [STATE_SIZE-1:0] rand_state();
    return STATE_SIZE'({$urandom(), $urandom()});
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int idle_bad;
    int t;
    logic [STATE_SIZE-1:0] st_a, st_b;
    logic [15:0] cmd_a, cmd_b;

    bus.start       = 1'b0;
    bus.write_value = '0;
    bus.miso        = 1'b0;
    rst             = 1'b1;
    wait_cycles(3);
    check("rst_ss", bus.ss, 1);
    check("rst_sck", bus.sck, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    rst = 1'b0;

    // Idle after reset: nothing moves without a start.
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ss !== 1'b1 || bus.sck !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.state_out !== '0 || bus.mosi !== 1'b0) idle_bad++;
    end
    check("reset_idle_bad_cycles", idle_bad, 0);

    // Directed frame from the test plan.
    issue_frame(41'h1_5A5A_C3C3_7E, 16'hBEEF);
    wait_done(1);

    // Randomised frames.
    for (int i = 0; i < 4; i++) begin
      issue_frame(rand_state(), 16'($urandom()));
      wait_done(n_issued);
    end

    // Back-to-back with start held high; write_value changes mid-frame.
    wait_idle();
    st_a  = rand_state();
    st_b  = rand_state();
    cmd_a = 16'($urandom());
    cmd_b = ~cmd_a;
    load_q.push_back(st_a);
    load_q.push_back(st_b);
    exp_q.push_back('{st_a, cmd_a, cyc});
    exp_q.push_back('{st_b, cmd_b, -1});
    n_issued += 2;
    bus.write_value = cmd_a;
    bus.start       = 1'b1;
    wait_cycles(50);
    bus.write_value = cmd_b;
    wait_done(n_issued - 1);
    t = 0;
    while (bus.ss && t < 4 * CLK_DIV) begin
      @(negedge clk);
      t++;
    end
    check("b2b_second_ss_fall", bus.ss, 0);
    bus.start = 1'b0;
    wait_done(n_issued);

    // Start while busy, including the last GAP cycle: all must be ignored.
    issue_frame(rand_state(), 16'($urandom()));
    wait_cycles(4);
    pulse_start();
    wait_cycles(94);
    pulse_start();
    wait_cycles(235);
    pulse_start();
    wait_cycles(3);
    pulse_start();
    wait_done(n_issued);
    wait_idle();
    wait_cycles(20);
    check("busy_start_ignored_dones", n_done, n_issued);

    // Asynchronous reset mid-frame.
    issue_frame(rand_state(), 16'($urandom()));
    wait_cycles(149);
    #2 rst = 1'b1;
    #1;
    check("midrst_ss_immediate", bus.ss, 1);
    check("midrst_sck_immediate", bus.sck, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_state_out", bus.state_out, 0);
    void'(exp_q.pop_back());
    n_issued--;
    @(negedge clk);
    check("midrst_no_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(10);
    check("after_rst_state_out", bus.state_out, 0);
    check("after_rst_dones", n_done, n_issued);
    issue_frame(rand_state(), 16'($urandom()));
    wait_done(n_issued);

    wait_idle();
    wait_cycles(10);
    check("frames_outstanding", exp_q.size(), 0);
    check("done_count", n_done, n_issued);
    check("state_out_stray_changes", so_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- SPI mode-0 controller for the game's SPI peripheral port: one frame per `start`.
- Each frame does two things at once: it reads back the packed game state (STATE_SIZE bits, MSB first, on MISO) and drives a 16-bit command word on MOSI.
- The peripheral commits the command word on every 16th SCK rising edge of a frame, so MOSI repeats the word every 16 bits. All commits in a frame therefore see the same value.
- The block sits in the test/host harness, or in a companion controller on the same clock domain.

Parameters:
- STATE_SIZE, 41, number of bits per frame; equals the peripheral state width; must be >= 16.
- CLK_DIV, 4, clk cycles per SCK half-period; must be >= 2 so the peripheral's one-flop edge detector sees every edge.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame request; accepted only in IDLE.
- write_value  input  16  command word; captured on the accepted start.
- busy  output  1  high from the cycle after start is accepted until GAP completes.
- done  output  1  one-cycle pulse when a frame completes; state_out is valid from the same cycle.
- state_out  output  STATE_SIZE  last received state; holds its value until the next done.
- sck  output  1  SPI clock; idles low.
- ss  output  1  active-low select; idles high.
- mosi  output  1  serial data to the peripheral.
- miso  input  1  serial data from the peripheral.

Behaviour:

Reset (asynchronous, takes effect immediately, including mid-frame):
- ss=1, sck=0, mosi=0, busy=0, done=0, state_out=0.
- FSM goes to IDLE; both counters clear.
- An aborted frame produces no done, and state_out is not updated.

FSM states: IDLE, LEAD, LOW, HIGH, TRAIL, GAP.
- A divider counter div counts 0..CLK_DIV-1.
- A bit counter bitn counts 0..STATE_SIZE-1.

IDLE:
- When start=1: latch write_value into cmd, clear div and bitn, go to LEAD.
- On the next cycle: ss=0, busy=1.
- start while busy is ignored; there is no queueing.

LEAD (CLK_DIV cycles):
- ss=0, sck=0, mosi=cmd[15].
- Gives the peripheral time to detect the ss falling edge and load its state.
- Then go to LOW with bitn=0.

LOW (CLK_DIV cycles):
- sck=0.
- mosi=cmd[15 - (bitn mod 16)], stable for the whole phase.
- On the final cycle: sample miso into rx shift register rx = {rx[STATE_SIZE-2:0], miso}, then go to HIGH.
- This sample is taken just before the rising edge. The peripheral changed MISO about 2 clks after the preceding falling edge, so the data is settled.

HIGH (CLK_DIV cycles):
- sck=1, mosi held.
- On the final cycle:
  - if bitn=STATE_SIZE-1, go to TRAIL;
  - otherwise bitn++ and go to LOW.

TRAIL (CLK_DIV cycles):
- sck=0, ss=0.
- Lets the peripheral register its final write.
- On exit: ss=1, done=1 for exactly one cycle, state_out<=rx; go to GAP.

GAP (CLK_DIV cycles):
- ss=1, busy=1 (enforces minimum ss-high time).
- Then go to IDLE with busy=0.
- A start in the same cycle busy falls is not accepted; start is first accepted in the following cycle.

Timing (start accepted at cycle 0):
- ss falls at cycle 1.
- The first sck rise is at cycle 1+2·CLK_DIV.
- done is at cycle 1+CLK_DIV·(2·STATE_SIZE+2); with defaults this is 337.
- busy falls CLK_DIV cycles after done.

Bit mapping:
- state_out[STATE_SIZE-1] is the first bit received.
- MOSI bit k is cmd[15-(k mod 16)], so the peripheral sees cmd at rising edges 16, 32, ….

Widths:
- div is $clog2(CLK_DIV) bits; bitn is $clog2(STATE_SIZE) bits.
- bit index arithmetic uses only the low 4 bits of bitn; no overflow is possible.

Test Plan:
- Reset then idle: apply rst, no start for 50 cycles -> ss=1, sck=0, busy=0, done=0, state_out=0 throughout.
- Single frame: defaults, peripheral model loaded with state 41'h1_5A5A_C3C3_7E → done at cycle 337 after start; state_out=41'h1_5A5A_C3C3_7E; exactly 41 sck rising edges; sck high and low phases each 4 clks.
- Command word: write_value=16'hBEEF → peripheral write_en pulses twice (after edges 16 and 32), both with value 16'hBEEF; MOSI bits 32..40 equal the first 9 bits of BEEF.
- Back-to-back: hold start=1 continuously → second ss fall comes CLK_DIV+1 cycles after the first done; write_value changed mid-frame does not affect the current frame.
- Start while busy: pulse start at cycles 5, 100 and 336 of a frame → no effect; exactly one done.
- Reset mid-frame: assert rst at cycle 150 → ss=1 and sck=0 in the same cycle (asynchronous); no done; state_out keeps its prior value (0). After release, a new frame completes normally with the correct data.
